// File: rtl/mips_div_pkg.sv
// Shared defines for the MIPS divider: FSM encoding, iteration count and helpers.
// Imported by the divider and by any datapath code that needs the same constants.
package mips_div_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_e;

    function automatic logic [31:0] negate(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/mips_div_if.sv
// E-stage divider port bundle: operands and control from the pipeline, result and stall back.
interface mips_div_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_div;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    modport master (
        output a, b, signed_div, start, annul,
        input  result, ready, stall_div
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output result, ready, stall_div
    );
endinterface

// File: rtl/mips_div.sv
// Multi-cycle restoring divider for DIV/DIVU: one shift-subtract step per cycle,
// result = {HI remainder, LO quotient}, stalls the pipeline until the result is ready.
module mips_div #(
    parameter int DIV_CYCLES = mips_div_pkg::DIV_CYCLES
) (
    input logic       clk,
    input logic       rst,
    mips_div_if.slave bus
);
    import mips_div_pkg::*;

    localparam int                CNT_W     = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    div_state_e       state, state_next;
    logic [64:0]      work, work_step;
    logic [33:0]      trial;
    logic [31:0]      divisor;
    logic [CNT_W-1:0] count;
    logic             neg_quot, neg_rem;
    logic [63:0]      result;
    logic             done, launch, step_en, load_div, load_zero;

    logic             a_neg, b_neg;
    logic [31:0]      a_mag, b_mag, quot_fix, rem_fix;

    assign a_neg = bus.signed_div & bus.a[31];
    assign b_neg = bus.signed_div & bus.b[31];
    assign a_mag = a_neg ? negate(bus.a) : bus.a;
    assign b_mag = b_neg ? negate(bus.b) : bus.b;

    // work = {partial remainder, quotient bits}; bits [64:31] are the shifted remainder.
    always_comb begin
        trial     = work[64:31] - {2'b00, divisor};
        work_step = {work[63:0], 1'b0};
        if (!trial[33])
            work_step = {trial[32:0], work[30:0], 1'b1};
    end

    assign quot_fix = neg_quot ? negate(work_step[31:0])  : work_step[31:0];
    assign rem_fix  = neg_rem  ? negate(work_step[63:32]) : work_step[63:32];

    always_ff @(posedge clk) begin
        if (rst)
            state <= FREE;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case leaves a latch.
        state_next = state;
        done       = 1'b0;
        launch     = 1'b0;
        step_en    = 1'b0;
        load_div   = 1'b0;
        load_zero  = 1'b0;
        unique case (state)
            FREE: begin
                if (bus.start && !bus.annul) begin
                    if (bus.b == 32'd0) begin
                        state_next = DIV_ZERO;
                    end else begin
                        state_next = DIV_ON;
                        launch     = 1'b1;
                    end
                end
            end
            DIV_ZERO: begin
                if (bus.annul || !bus.start) begin
                    state_next = FREE;
                end else begin
                    state_next = DIV_END;
                    load_zero  = 1'b1;
                end
            end
            DIV_ON: begin
                if (bus.annul || !bus.start) begin
                    state_next = FREE;
                end else begin
                    step_en = 1'b1;
                    if (count == LAST_STEP) begin
                        state_next = DIV_END;
                        load_div   = 1'b1;
                    end
                end
            end
            DIV_END: begin
                state_next = FREE;
                done       = bus.start & ~bus.annul;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            divisor  <= '0;
            count    <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else begin
            if (launch) begin
                work     <= {33'd0, a_mag};
                divisor  <= b_mag;
                count    <= '0;
                neg_quot <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
                neg_rem  <= a_neg;
            end else if (step_en) begin
                work  <= work_step;
                count <= count + CNT_W'(1);
            end
            if (load_div)
                result <= {rem_fix, quot_fix};
            else if (load_zero)
                result <= '0;
        end
    end

    assign bus.result    = result;
    assign bus.ready     = done;
    assign bus.stall_div = bus.start & ~done;

endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div: vector table through a scoreboard queue,
// plus directed sequences for annul, start drop, back-to-back issue and mid-op reset.
module tb_mips_div;

    logic clk = 1'b0;
    logic rst;

    mips_div_if bus ();

    mips_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sd;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: ready with empty scoreboard got=%h", name, bus.result);
        end else begin
            check(name, bus.result, exp_q.pop_front());
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sd);
        logic signed [31:0] sx, sy, q, r;
        sx = x;
        sy = y;
        if (y == 32'd0) return 64'd0;
        if (!sd) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.ready)
            check("ready_vs_stall", {63'd0, bus.stall_div}, 64'd0);
    end

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic sd, input logic [63:0] exp, input int exp_lat);
        int cyc;
        bit got;
        bit stall_ok;
        @(posedge clk);
        #1;
        bus.a          = av;
        bus.b          = bv;
        bus.signed_div = sd;
        bus.annul      = 1'b0;
        bus.start      = 1'b1;
        exp_q.push_back(exp);
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
                pop_check({name, "_result"});
            end else begin
                if (!bus.stall_div) stall_ok = 1'b0;
                if (cyc > 0) begin
                    bus.a          = $urandom;
                    bus.b          = $urandom;
                    bus.signed_div = $urandom_range(0, 1);
                end
                cyc++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got=no_ready want=ready_at_%0d", name, exp_lat);
            exp_q.delete();
        end
        check({name, "_stall"}, {63'd0, stall_ok}, 64'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({name, "_hold"}, bus.result, exp);
        check({name, "_ready_off"}, {63'd0, bus.ready}, 64'd0);
    endtask

    initial begin
        int          cyc;
        int          n_ready;
        int          ready_cyc[2];
        bit          seen;
        bit          op2_sent;
        logic [31:0] ra, rb;
        logic        rsd;

        rst            = 1'b1;
        bus.a          = '0;
        bus.b          = '0;
        bus.signed_div = 1'b0;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_result", bus.result, 64'd0);
        check("reset_ready", {63'd0, bus.ready}, 64'd0);
        check("reset_stall", {63'd0, bus.stall_div}, 64'd0);

        vecs.push_back('{32'd7,          32'd2,          1'b0, 64'h00000001_00000003, 33});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 33});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33});
        vecs.push_back('{32'd5,          32'd0,          1'b0, 64'h00000000_00000000, 2});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1,          1'b0, 64'h00000000_FFFFFFFF, 33});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2,          1'b0, 64'h00000001_7FFFFFFC, 33});
        vecs.push_back('{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33});
        vecs.push_back('{32'd0,          32'd0,          1'b1, 64'h00000000_00000000, 2});
        vecs.push_back('{32'd3,          32'd10,         1'b0, 64'h00000003_00000000, 33});
        for (int i = 0; i < 4; i++) begin
            ra  = $urandom;
            rb  = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            rsd = i[0];
            if (rb == 32'd0) rb = 32'd1;
            vecs.push_back('{ra, rb, rsd, model(ra, rb, rsd), 33});
        end

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sd, vecs[i].exp, vecs[i].lat);

        // Annul in cycle 10, then a new operation issued the very next cycle.
        @(posedge clk);
        #1;
        bus.a          = 32'd1234;
        bus.b          = 32'd5;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        seen           = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.annul = 1'b1;
        @(negedge clk);
        if (bus.ready) seen = 1'b1;
        check("annul_no_ready", {63'd0, seen}, 64'd0);
        run_op("after_annul", 32'd100, 32'd10, 1'b1, 64'h00000000_0000000A, 33);

        // Start dropped mid-operation: no ready pulse may follow.
        @(posedge clk);
        #1;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) seen = 1'b1;
        end
        check("start_drop_no_ready", {63'd0, seen}, 64'd0);
        run_op("after_drop", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

        // Two DIVU back to back with start held continuously.
        @(posedge clk);
        #1;
        bus.a          = 32'd1000;
        bus.b          = 32'd3;
        bus.signed_div = 1'b0;
        bus.start      = 1'b1;
        exp_q.push_back(64'h00000001_0000014D);
        cyc          = 0;
        n_ready      = 0;
        ready_cyc[0] = -1;
        ready_cyc[1] = -1;
        op2_sent     = 1'b0;
        while (n_ready < 2 && cyc < 90) begin
            @(negedge clk);
            if (bus.ready) begin
                ready_cyc[n_ready] = cyc;
                n_ready++;
                pop_check($sformatf("b2b_result%0d", n_ready));
            end
            @(posedge clk);
            #1;
            if (n_ready == 1 && !op2_sent) begin
                bus.a    = 32'd50;
                bus.b    = 32'd7;
                op2_sent = 1'b1;
                exp_q.push_back(64'h00000001_00000007);
            end
            cyc++;
        end
        bus.start = 1'b0;
        check("b2b_pulses", 64'(n_ready), 64'd2);
        check("b2b_first_cycle", 64'(ready_cyc[0]), 64'd33);
        check("b2b_second_cycle", 64'(ready_cyc[1]), 64'd67);
        exp_q.delete();

        // Reset in the middle of an operation with start still high.
        @(posedge clk);
        #1;
        bus.a     = 32'd77;
        bus.b     = 32'd5;
        bus.start = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready) seen = 1'b1;
        end
        check("midreset_no_ready", {63'd0, seen}, 64'd0);
        check("midreset_result", bus.result, 64'd0);
        check("midreset_stall", {63'd0, bus.stall_div}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_div.md
MIPS_DIV -- requirements
Module: mips_div

Interface
- REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning.
  - clk  in  1  the single clock; all state changes on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - a  in  32  dividend (rs value in E stage).
  - b  in  32  divisor (rt value in E stage).
  - signed_div  in  1  1 = DIV, 0 = DIVU.
  - start  in  1  E-stage instruction is DIV/DIVU and valid; held high while stalled.
  - annul  in  1  flush from exception logic (flushALL); aborts any operation.
  - result  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
  - ready  out  1  result valid this cycle.
  - stall_div  out  1  drives the hazard unit's stall_divE input.
- REQ-002 The block SHALL have one parameter: DIV_CYCLES, default 32, giving the number of shift-subtract iterations (not to be overridden in this design).

Function
- REQ-003 The block SHALL have four states: FREE, DIV_ZERO, DIV_ON and DIV_END.
- REQ-004 FREE SHALL transition as follows:
  - start=1, annul=0, b!=0 -> DIV_ON;
  - start=1, annul=0, b==0 -> DIV_ZERO;
  - otherwise remain in FREE.
- REQ-005 On the FREE->DIV_ON edge, the block SHALL latch the operand magnitudes, the sign of a and the sign of a XOR the sign of b:
  - magnitudes are two's-complement negated when signed_div=1 and the operand is negative;
  - otherwise operands are taken as unsigned;
  - the iteration counter SHALL be cleared to 0.
- REQ-006 DIV_ON SHALL perform one restoring shift-subtract step per cycle on a 65-bit working register and increment the counter.
- REQ-007 DIV_ON SHALL go to DIV_END after the step where the counter reaches DIV_CYCLES-1, i.e. after exactly 32 cycles in DIV_ON.
- REQ-008 In DIV_ZERO, the block SHALL load result 0 and go to DIV_END after 1 cycle.
- REQ-009 Sign fix-up for signed_div=1 SHALL be:
  - quotient negated if the latched sign XOR is 1;
  - remainder negated if the dividend was negative.
- REQ-010 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0 (natural 32-bit wrap, no trap).
- REQ-011 DIV_END SHALL assert ready for exactly one cycle with result valid, then return to FREE unconditionally.
- REQ-012 result SHALL be registered and hold its last value outside DIV_END.
- REQ-013 stall_div SHALL equal start & ~ready (combinational), so the pipeline advances in the ready cycle.
- REQ-014 Latency SHALL be measured from the first cycle start is high in FREE:
  - b!=0: ready in cycle +33, giving 34 cycles total with stall_div high for the first 33;
  - b==0: ready in cycle +2.
- REQ-015 Changes on a, b or signed_div after launch SHALL be ignored.
- REQ-016 Back-to-back: a new start seen in FREE on the cycle after DIV_END SHALL launch a new operation normally.
- REQ-017 Aborts from DIV_ON, DIV_ZERO or DIV_END SHALL behave as follows:
  - annul=1 in any of these states -> FREE next cycle, ready stays 0;
  - start=0 in any of these states -> FREE next cycle, ready stays 0;
  - annul has priority over start.
- REQ-018 ready and stall_div SHALL never both be 1 in the same cycle.

Reset
- REQ-019 On rst=1 at a clock edge, the block SHALL enter FREE with counter=0, working register=0 and result=0; ready=0.
- REQ-020 stall_div SHALL follow REQ-013 (it is combinational), so it is 0 whenever start=0.
- REQ-021 Reset mid-operation SHALL discard the operation; the same cycle's start is not sampled.

Structure
- REQ-022 The state encoding (2-bit localparams FREE/DIV_ZERO/DIV_ON/DIV_END) and DIV_CYCLES SHALL live in the shared CPU defines package used by the datapath.
- REQ-023 The block SHALL be a single module with no sub-module; the negate function may be a local function.
- REQ-024 The block SHALL be instantiated in the E stage; stall_div wires to stall_divE, annul to flushALL, and result to the E-stage HI/LO write data.

Verification
- REQ-025 The bench SHALL cover the following directed scenarios:
  - DIVU a=7, b=2, start held -> ready in cycle 33 with result=0x00000001_00000003; stall_div high for cycles 0..32.
  - DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=7, b=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
  - DIVU a=5, b=0 -> ready in cycle 2, result=0.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
  - annul pulsed in cycle 10 of DIV_ON -> no ready pulse; FREE next cycle; a following start with a=100, b=10 yields LO=10, HI=0 at its cycle 33.
  - Two consecutive DIVU instructions (start continuously high) -> two ready pulses 34 cycles apart, each with the correct result; rst asserted mid-operation -> ready stays 0 and result=0.
